// File: rtl/yuv422_to_yuv444_ext.sv
// 4:2:2 -> 4:4:4 chroma upsampler (duplicate or linear interpolate, mode latched per line).
// Latency 4 clocks (5 with YUV444_RANGE_CLAMP_EN clamp stage); no backpressure, pure streaming.
// Optional macro YUV444_RANGE_CLAMP_EN adds a BT.601 legal-range clamp register stage.
module yuv422_to_yuv444_ext #(
    parameter int DATA_W   = 8,
    parameter bit CB_FIRST = 1'b1,
    parameter int LAT      = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              interp_i,
    input  logic [DATA_W-1:0] y_i,
    input  logic [DATA_W-1:0] cbcr_i,
    input  logic              de_i,
    input  logic              hs_i,
    input  logic              vs_i,
    output logic [DATA_W-1:0] y_o,
    output logic [DATA_W-1:0] cb_o,
    output logic [DATA_W-1:0] cr_o,
    output logic              de_o,
    output logic              hs_o,
    output logic              vs_o
);

    generate
        if (LAT != 4) begin : g_lat_chk
            $error("yuv422_to_yuv444_ext: LAT must be 4");
        end
    endgenerate

    localparam logic [DATA_W-1:0] MID = {1'b1, {(DATA_W-1){1'b0}}};

    typedef struct packed {
        logic              de;
        logic              hs;
        logic              vs;
        logic              ph;
        logic              md;
        logic [DATA_W-1:0] y;
        logic [DATA_W-1:0] c;
    } stage_t;

    stage_t            s0, s1, s2;
    logic [DATA_W-1:0] p_c;
    logic              p_de;
    logic              armed, phase, mode;
    logic              de_eff, rise, mode_cur;

    // A line cut by reset is dropped until de_i has been seen low again.
    assign de_eff   = de_i & armed;
    assign rise     = de_eff & ~s0.de;
    assign mode_cur = rise ? interp_i : mode;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            armed <= 1'b0;
            phase <= 1'b0;
            mode  <= 1'b0;
            s0    <= '0;
            s1    <= '0;
            s2    <= '0;
            p_c   <= '0;
            p_de  <= 1'b0;
        end else begin
            if (!de_i) begin
                armed <= 1'b1;
            end
            phase <= de_eff ? ~phase : 1'b0;
            mode  <= mode_cur;
            s0.de <= de_eff;
            s0.hs <= hs_i;
            s0.vs <= vs_i;
            s0.ph <= phase;
            s0.md <= mode_cur;
            s0.y  <= y_i;
            s0.c  <= cbcr_i;
            s1    <= s0;
            s2    <= s1;
            p_c   <= s2.c;
            p_de  <= s2.de;
        end
    end

    // s2 is the pixel being emitted; s1/s0 are the next two samples, p_* the previous one.
    logic [DATA_W:0]   sum_a, sum_b;
    logic [DATA_W-1:0] a_n, b_n;

    assign sum_a = {1'b0, p_c}  + {1'b0, s1.c} + (DATA_W+1)'(1);
    assign sum_b = {1'b0, s2.c} + {1'b0, s0.c} + (DATA_W+1)'(1);

    always_comb begin
        a_n = s2.c;
        b_n = MID;
        if (!s2.ph) begin
            if (s1.de) begin
                b_n = s1.c;
            end else if (p_de) begin
                b_n = p_c;
            end
        end else begin
            a_n = p_c;
            b_n = s2.c;
            if (s2.md) begin
                if (s1.de) begin
                    a_n = DATA_W'(sum_a >> 1);
                end
                if (s1.de && s0.de) begin
                    b_n = DATA_W'(sum_b >> 1);
                end
            end
        end
    end

    logic [DATA_W-1:0] y_q, cb_q, cr_q;
    logic              de_q, hs_q, vs_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            y_q  <= '0;
            cb_q <= MID;
            cr_q <= MID;
            de_q <= 1'b0;
            hs_q <= 1'b0;
            vs_q <= 1'b0;
        end else begin
            y_q  <= s2.y;
            de_q <= s2.de;
            hs_q <= s2.hs;
            vs_q <= s2.vs;
            if (s2.de) begin
                cb_q <= CB_FIRST ? a_n : b_n;
                cr_q <= CB_FIRST ? b_n : a_n;
            end
        end
    end

`ifdef YUV444_RANGE_CLAMP_EN
    localparam logic [DATA_W-1:0] LO   = DATA_W'(16  << (DATA_W-8));
    localparam logic [DATA_W-1:0] HI_Y = DATA_W'(235 << (DATA_W-8));
    localparam logic [DATA_W-1:0] HI_C = DATA_W'(240 << (DATA_W-8));

    function automatic logic [DATA_W-1:0] clip(input logic [DATA_W-1:0] v,
                                               input logic [DATA_W-1:0] hi);
        return (v < LO) ? LO : ((v > hi) ? hi : v);
    endfunction

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            y_o  <= '0;
            cb_o <= MID;
            cr_o <= MID;
            de_o <= 1'b0;
            hs_o <= 1'b0;
            vs_o <= 1'b0;
        end else begin
            y_o  <= clip(y_q, HI_Y);
            cb_o <= clip(cb_q, HI_C);
            cr_o <= clip(cr_q, HI_C);
            de_o <= de_q;
            hs_o <= hs_q;
            vs_o <= vs_q;
        end
    end
`else
    assign y_o  = y_q;
    assign cb_o = cb_q;
    assign cr_o = cr_q;
    assign de_o = de_q;
    assign hs_o = hs_q;
    assign vs_o = vs_q;
`endif

endmodule

// File: tb/tb_yuv422_to_yuv444_ext.sv
// Scoreboard bench: driver pushes expected per-cycle outputs from a line-level model,
// negedge monitor pops and compares both Cb-first and Cr-first instances.
module tb_yuv422_to_yuv444_ext;
    localparam int MIDV = 128;
`ifdef YUV444_RANGE_CLAMP_EN
    localparam int LATN = 5;
`else
    localparam int LATN = 4;
`endif

    logic       clk = 1'b0;
    logic       rst_n, interp_i, de_i, hs_i, vs_i;
    logic [7:0] y_i, cbcr_i;
    logic [7:0] y1, cb1, cr1, y0, cb0, cr0;
    logic       de1, hs1, vs1, de0, hs0, vs0;

    always #5 clk = ~clk;

    yuv422_to_yuv444_ext #(.DATA_W(8), .CB_FIRST(1'b1), .LAT(4)) dut1 (
        .clk(clk), .rst_n(rst_n), .interp_i(interp_i), .y_i(y_i), .cbcr_i(cbcr_i),
        .de_i(de_i), .hs_i(hs_i), .vs_i(vs_i), .y_o(y1), .cb_o(cb1), .cr_o(cr1),
        .de_o(de1), .hs_o(hs1), .vs_o(vs1));

    yuv422_to_yuv444_ext #(.DATA_W(8), .CB_FIRST(1'b0), .LAT(4)) dut0 (
        .clk(clk), .rst_n(rst_n), .interp_i(interp_i), .y_i(y_i), .cbcr_i(cbcr_i),
        .de_i(de_i), .hs_i(hs_i), .vs_i(vs_i), .y_o(y0), .cb_o(cb0), .cr_o(cr0),
        .de_o(de0), .hs_o(hs0), .vs_o(vs0));

    typedef struct {
        bit raw;
        bit chk;
        bit de;
        bit hs;
        bit vs;
        int y;
        int a;
        int b;
    } exp_t;

    exp_t q[$];
    int   tests = 0;
    int   fails = 0;
    bit   en = 1'b0;
    int   last_a = MIDV;
    int   last_b = MIDV;
    int   lc[16];
    int   ly[16];

    function automatic int clampv(int v, int lo, int hi);
        return (v < lo) ? lo : ((v > hi) ? hi : v);
    endfunction

    function automatic int fy(exp_t e);
`ifdef YUV444_RANGE_CLAMP_EN
        return e.raw ? e.y : clampv(e.y, 16, 235);
`else
        return e.y;
`endif
    endfunction

    function automatic int fc(exp_t e, int v);
`ifdef YUV444_RANGE_CLAMP_EN
        return e.raw ? v : clampv(v, 16, 240);
`else
        return v;
`endif
    endfunction

    task automatic chk(string name, int act, int expv);
        tests++;
        if (act != expv) begin
            fails++;
            $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, expv);
        end
    endtask

    always @(negedge clk) begin
        if (en) begin
            if (q.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL scoreboard at %0t: got empty queue expected an entry", $time);
            end else begin
                exp_t e;
                e = q.pop_front();
                chk("y_cbfirst", int'(y1), fy(e));
                chk("de_cbfirst", int'(de1), int'(e.de));
                chk("hs_cbfirst", int'(hs1), int'(e.hs));
                chk("vs_cbfirst", int'(vs1), int'(e.vs));
                chk("y_crfirst", int'(y0), fy(e));
                chk("de_crfirst", int'(de0), int'(e.de));
                if (e.chk) begin
                    chk("cb_cbfirst", int'(cb1), fc(e, e.a));
                    chk("cr_cbfirst", int'(cr1), fc(e, e.b));
                    chk("cb_crfirst", int'(cb0), fc(e, e.b));
                    chk("cr_crfirst", int'(cr0), fc(e, e.a));
                end
            end
        end
    end

    // a = chroma carried by the first sample of each pair, b = the second.
    task automatic cyc(bit de, int y, int c, bit md, int a, int b, bit ck);
        exp_t e;
        de_i     = de;
        y_i      = 8'(y);
        cbcr_i   = 8'(c);
        interp_i = md;
        hs_i     = 1'($urandom);
        vs_i     = 1'($urandom);
        e.raw = 1'b0;
        e.de  = de;
        e.hs  = hs_i;
        e.vs  = vs_i;
        e.y   = y;
        if (de) begin
            e.a = a;
            e.b = b;
            e.chk = ck;
            if (ck) begin
                last_a = a;
                last_b = b;
            end
        end else begin
            e.a = last_a;
            e.b = last_b;
            e.chk = 1'b1;
        end
        q.push_back(e);
        @(posedge clk);
        #1;
    endtask

    task automatic idle(int n, bit md);
        for (int i = 0; i < n; i++) begin
            cyc(1'b0, int'($urandom_range(0, 255)), int'($urandom_range(0, 255)), md, 0, 0, 1'b1);
        end
    endtask

    task automatic line(int len, bit md, bit toggle, bit abort);
        int a, b;
        bit drv;
        for (int n = 0; n < len; n++) begin
            if (n % 2 == 0) begin
                a = lc[n];
                if (n + 1 < len)   b = lc[n+1];
                else if (n > 0)    b = lc[n-1];
                else               b = MIDV;
            end else begin
                a = lc[n-1];
                b = lc[n];
                if (md) begin
                    if (n + 1 < len) a = (a + lc[n+1] + 1) / 2;
                    if (n + 2 < len) b = (b + lc[n+2] + 1) / 2;
                end
            end
            drv = (toggle && n >= 1) ? ~md : md;
            cyc(1'b1, ly[n], lc[n], drv, a, b, ~abort);
        end
    endtask

    task automatic fill_rand();
        for (int i = 0; i < 16; i++) begin
            ly[i] = int'($urandom_range(0, 255));
            case ($urandom_range(0, 3))
                0:       lc[i] = 0;
                1:       lc[i] = 255;
                default: lc[i] = int'($urandom_range(0, 255));
            endcase
        end
    endtask

    task automatic do_reset();
        exp_t e;
        rst_n  = 1'b0;
        de_i   = 1'b0;
        hs_i   = 1'b0;
        vs_i   = 1'b0;
        y_i    = 8'd0;
        cbcr_i = 8'd0;
        e.raw = 1'b1;
        e.chk = 1'b1;
        e.de  = 1'b0;
        e.hs  = 1'b0;
        e.vs  = 1'b0;
        e.y   = 0;
        e.a   = MIDV;
        e.b   = MIDV;
        if (q.size() == 0) q.push_back(e);
        while (q.size() > 1) void'(q.pop_back());
        q.push_back(e);
        e.raw = 1'b0;
        for (int i = 1; i < LATN; i++) q.push_back(e);
        last_a = MIDV;
        last_b = MIDV;
        en = 1'b1;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    initial begin
        rst_n = 1'b0; interp_i = 1'b0; de_i = 1'b0; hs_i = 1'b0; vs_i = 1'b0;
        y_i = 8'd0; cbcr_i = 8'd0;
        @(posedge clk);
        #1;
        do_reset();
        idle(3, 1'b0);

        for (int i = 0; i < 4; i++) begin
            lc[i] = 10 * (i + 1);
            ly[i] = i + 1;
        end
        line(4, 1'b0, 1'b0, 1'b0);
        idle(2, 1'b1);
        line(4, 1'b1, 1'b0, 1'b0);
        idle(2, 1'b1);

        lc[0] = 10; lc[1] = 99; lc[2] = 13; lc[3] = 50;
        line(4, 1'b1, 1'b0, 1'b0);
        idle(2, 1'b0);

        lc[0] = 10; lc[1] = 20; lc[2] = 30;
        line(3, 1'b0, 1'b0, 1'b0);
        idle(2, 1'b0);
        lc[0] = 77;
        ly[0] = 9;
        line(1, 1'b0, 1'b0, 1'b0);
        idle(3, 1'b1);

        lc[0] = 50; lc[1] = 60; lc[2] = 5; lc[3] = 250;
        ly[0] = 250; ly[1] = 3; ly[2] = 240; ly[3] = 10;
        line(4, 1'b1, 1'b0, 1'b0);
        idle(2, 1'b0);

        fill_rand();
        line(6, 1'b0, 1'b1, 1'b0);
        idle(2, 1'b1);
        fill_rand();
        line(7, 1'b1, 1'b1, 1'b0);
        idle(1, 1'b1);

        fill_rand();
        line(5, 1'b1, 1'b0, 1'b1);
        do_reset();
        idle(3, 1'b0);
        for (int i = 0; i < 4; i++) begin
            lc[i] = 10 * (i + 1);
            ly[i] = i + 1;
        end
        line(4, 1'b0, 1'b0, 1'b0);
        idle(2, 1'b0);

        repeat (60) begin
            fill_rand();
            line(int'($urandom_range(1, 11)), 1'($urandom), 1'($urandom_range(0, 3) == 0), 1'b0);
            idle(int'($urandom_range(1, 3)), 1'($urandom));
        end

        idle(LATN + 2, 1'b0);
        en = 1'b0;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
